// File: rtl/regfile_hilo.sv
// regfile_hilo: 2R/1W GPR file with r0 hardwired to zero, plus HI/LO pair.
// Optional same-cycle write-through forwarding under REGFILE_BYPASS_EN.
`ifndef N_REG_ADDR
`define N_REG_ADDR 5
`endif
`ifndef N_REG
`define N_REG 32
`endif
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif

module regfile_hilo (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wb_wen,
  input  logic [`N_REG_ADDR-1:0] i_wb_waddr,
  input  logic [`N_REG-1:0]      i_wb_wdata,
  input  logic                   i_wb_hilo_wen,
  input  logic [`N_REG-1:0]      i_wb_hi,
  input  logic [`N_REG-1:0]      i_wb_lo,
  input  logic                   i_re1,
  input  logic                   i_re2,
  input  logic [`N_REG_ADDR-1:0] i_raddr1,
  input  logic [`N_REG_ADDR-1:0] i_raddr2,
  output logic [`N_REG-1:0]      o_rdata1,
  output logic [`N_REG-1:0]      o_rdata2,
  output logic [`N_REG-1:0]      o_hi,
  output logic [`N_REG-1:0]      o_lo
);

  localparam int NUM = 1 << `N_REG_ADDR;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [`N_REG-1:0] gpr [NUM];
  logic [`N_REG-1:0] hi_q;
  logic [`N_REG-1:0] lo_q;
  logic              rst_on;
  logic              gpr_we;
  logic              fwd1;
  logic              fwd2;
  logic              fwd_hl;

  assign rst_on = (i_rst_n == `RST_ENABLE);
  assign gpr_we = i_wb_wen && (i_wb_waddr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        gpr[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr[i_wb_waddr] <= i_wb_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (i_wb_hilo_wen) begin
      hi_q <= i_wb_hi;
      lo_q <= i_wb_lo;
    end
  end

  // forwarding keys off gpr_we so r0 can never be bypassed
  assign fwd1   = BYPASS && gpr_we && (i_raddr1 == i_wb_waddr);
  assign fwd2   = BYPASS && gpr_we && (i_raddr2 == i_wb_waddr);
  assign fwd_hl = BYPASS && i_wb_hilo_wen;

  always_comb begin
    o_rdata1 = '0;
    if (!rst_on && i_re1 && (i_raddr1 != '0)) begin
      o_rdata1 = fwd1 ? i_wb_wdata : gpr[i_raddr1];
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (!rst_on && i_re2 && (i_raddr2 != '0)) begin
      o_rdata2 = fwd2 ? i_wb_wdata : gpr[i_raddr2];
    end
  end

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (!rst_on) begin
      o_hi = fwd_hl ? i_wb_hi : hi_q;
      o_lo = fwd_hl ? i_wb_lo : lo_q;
    end
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: vector table through a scoreboard queue,
// plus hand-written reset sequences.
`timescale 1ns/1ps

module tb_regfile_hilo;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hwen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        hwen = 1'b0;
  logic [31:0] whi = '0;
  logic [31:0] wlo = '0;
  logic        re1 = 1'b0;
  logic        re2 = 1'b0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] ohi;
  logic [31:0] olo;

  int checks = 0;
  int failures = 0;
  vec_t vt[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_hilo dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_wb_wen(wen),
    .i_wb_waddr(waddr),
    .i_wb_wdata(wdata),
    .i_wb_hilo_wen(hwen),
    .i_wb_hi(whi),
    .i_wb_lo(wlo),
    .i_re1(re1),
    .i_re2(re2),
    .i_raddr1(ra1),
    .i_raddr2(ra2),
    .o_rdata1(rd1),
    .o_rdata2(rd2),
    .o_hi(ohi),
    .o_lo(olo)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wen = v.wen; waddr = v.waddr; wdata = v.wdata;
    hwen = v.hwen; whi = v.hi; wlo = v.lo;
    re1 = v.re1; ra1 = v.ra1;
    re2 = v.re2; ra2 = v.ra2;
  endtask

  task automatic add(input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic hw,
                     input logic [31:0] h, input logic [31:0] l,
                     input logic r1, input logic [4:0] a1,
                     input logic r2, input logic [4:0] a2,
                     input logic [31:0] x1, input logic [31:0] x2,
                     input logic [31:0] xh, input logic [31:0] xl);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd;
    v.hwen = hw; v.hi = h; v.lo = l;
    v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
    v.e_rd1 = x1; v.e_rd2 = x2; v.e_hi = xh; v.e_lo = xl;
    vt.push_back(v);
  endtask

  task automatic read_all(input string nm,
                          input logic [31:0] x1,
                          input logic [31:0] x2,
                          input logic [31:0] xh,
                          input logic [31:0] xl);
    chk({nm, "_rd1"}, rd1, x1);
    chk({nm, "_rd2"}, rd2, x2);
    chk({nm, "_hi"}, ohi, xh);
    chk({nm, "_lo"}, olo, xl);
  endtask

  task automatic idle();
    wen = 1'b0; hwen = 1'b0; re1 = 1'b0; re2 = 1'b0;
    waddr = '0; wdata = '0; whi = '0; wlo = '0;
    ra1 = '0; ra2 = '0;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;
  localparam logic [31:0] H1 = 32'h11112222;
  localparam logic [31:0] L1 = 32'h33334444;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] R31 = 32'h55AA55AA;

  initial begin
    // vector table: state carried between rows, all-zero after reset
    add(0,0,0, 0,0,0, 1,5, 1,5, 0,0, 0,0);
    add(1,7,DB, 0,0,0, 1,7, 0,7, BYP ? DB : 0,0, 0,0);
    add(0,0,0, 0,0,0, 1,7, 1,7, DB,DB, 0,0);
    add(0,0,0, 0,0,0, 0,7, 1,7, 0,DB, 0,0);
    add(1,0,32'h12345678, 0,0,0, 1,0, 1,0, 0,0, 0,0);
    add(0,0,0, 0,0,0, 1,0, 1,0, 0,0, 0,0);
    add(1,9,1, 0,0,0, 0,0, 0,0, 0,0, 0,0);
    add(1,9,A5, 0,0,0, 1,9, 1,9,
        BYP ? A5 : 1, BYP ? A5 : 1, 0,0);
    add(0,0,0, 0,0,0, 1,9, 1,9, A5,A5, 0,0);
    add(1,3,CF, 1,H1,L1, 1,3, 0,0,
        BYP ? CF : 0, 0, BYP ? H1 : 0, BYP ? L1 : 0);
    add(0,0,0, 0,0,0, 1,3, 1,7, CF,DB, H1,L1);
    add(1,31,R31, 1,1,2, 1,31, 1,9,
        BYP ? R31 : 0, A5, BYP ? 1 : H1, BYP ? 2 : L1);
    add(0,0,0, 0,0,0, 1,31, 1,31, R31,R31, 1,2);
    add(0,5,32'hFFFF, 0,0,0, 1,5, 1,5, 0,0, 1,2);
    add(0,0,0, 0,0,0, 1,5, 1,31, 0,R31, 1,2);

    // held in reset with write and read activity
    rst_n = 1'b0;
    wen = 1'b1; waddr = 5; wdata = 32'h77;
    hwen = 1'b1; whi = 32'h9; wlo = 32'h8;
    re1 = 1'b1; ra1 = 5; re2 = 1'b1; ra2 = 31;
    #2;
    read_all("rst_hold", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    read_all("rst_edge", 0, 0, 0, 0);
    idle();
    rst_n = 1'b1;
    re1 = 1'b1; ra1 = 5; re2 = 1'b1; ra2 = 31;
    #2;
    read_all("rst_rel", 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      exp_t e;
      @(negedge clk);
      drive(vt[i]);
      e.rd1 = vt[i].e_rd1; e.rd2 = vt[i].e_rd2;
      e.hi = vt[i].e_hi; e.lo = vt[i].e_lo;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        exp_t g;
        g = sb.pop_front();
        read_all($sformatf("vec%0d", i), g.rd1, g.rd2, g.hi, g.lo);
      end
    end

    // reset asserted between edges while a write to r4 is pending
    @(negedge clk);
    idle();
    wen = 1'b1; waddr = 4; wdata = 32'hFF;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    re1 = 1'b1; ra1 = 4; re2 = 1'b1; ra2 = 7;
    #2;
    read_all("midrst", 0, 0, 0, 0);

    // first edge after release performs a normal write
    @(negedge clk);
    idle();
    wen = 1'b1; waddr = 4; wdata = 32'hFF;
    hwen = 1'b1; whi = 32'h5; wlo = 32'h6;
    @(negedge clk);
    idle();
    re1 = 1'b1; ra1 = 4; re2 = 1'b1; ra2 = 4;
    #2;
    read_all("post_rst", 32'hFF, 32'hFF, 32'h5, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous active-low reset:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous, active-low reset; asserted when equal to `RST_ENABLE.

REQ-002 Write-back ports (driven from the MEM/WB pipeline stage) SHALL be:
- i_wb_wen  in  1  GPR write enable.
- i_wb_waddr  in  `N_REG_ADDR  GPR write address.
- i_wb_wdata  in  `N_REG  GPR write data.
- i_wb_hilo_wen  in  1  HI/LO write enable.
- i_wb_hi  in  `N_REG  HI write data.
- i_wb_lo  in  `N_REG  LO write data.

REQ-003 Read ports SHALL be:
- i_re1, i_re2  in  1  read enables.
- i_raddr1, i_raddr2  in  `N_REG_ADDR  read addresses.
- o_rdata1, o_rdata2  out  `N_REG  read data.
- o_hi, o_lo  out  `N_REG  current HI/LO values.

Function
REQ-004 Storage SHALL be 2^`N_REG_ADDR general-purpose registers of `N_REG bits, plus one HI register and one LO register.

REQ-005 GPR write timing:
- On a rising edge with i_wb_wen=1 and i_wb_waddr!=0, the GPR at i_wb_waddr SHALL take i_wb_wdata.
- The new value SHALL be visible to reads in the next cycle.

REQ-006 A write to address 0 SHALL be discarded; GPR0 SHALL always read as 0.

REQ-007 HI/LO write timing: on a rising edge with i_wb_hilo_wen=1, HI and LO SHALL take i_wb_hi and i_wb_lo together, in the same edge.

REQ-008 Both read ports SHALL be combinational (zero-cycle latency) and independent of each other.

REQ-009 o_rdataN SHALL be 0 when i_reN=0, or when i_raddrN=0, regardless of any write activity.

REQ-010 When i_reN=1 and i_raddrN!=0, o_rdataN SHALL equal the stored GPR value, except as modified by REQ-015.

REQ-011 o_hi and o_lo SHALL reflect the stored HI/LO values, except as modified by REQ-016.

REQ-012 Both read ports addressing the same register SHALL return identical data.

REQ-013 GPR writes and HI/LO writes in the same cycle SHALL both take effect, with no priority between them.

Reset
REQ-014 Reset behaviour:
- While i_rst_n=0, every GPR, HI and LO SHALL be 0 asynchronously, and all writes SHALL be ignored.
- While i_rst_n=0, o_rdata1, o_rdata2, o_hi and o_lo SHALL all read 0.
- If reset asserts mid-cycle during a pending write, that write SHALL be lost.
- After reset deasserts, the first rising edge SHALL perform normal writes.

Configuration
REQ-015 Macro REGFILE_BYPASS_EN controls same-cycle GPR forwarding:
- When defined: if i_reN=1, i_raddrN!=0, i_wb_wen=1 and i_raddrN==i_wb_waddr, o_rdataN SHALL equal i_wb_wdata in the same cycle (write-through).
- When not defined: o_rdataN SHALL return the pre-edge stored value, and the write SHALL be visible only from the next cycle.

REQ-016 Macro REGFILE_BYPASS_EN controls same-cycle HI/LO forwarding:
- When defined and i_wb_hilo_wen=1: o_hi/o_lo SHALL equal i_wb_hi/i_wb_lo combinationally.
- When not defined: o_hi/o_lo SHALL equal the stored HI/LO values only.

Verification
REQ-017 Reset: hold i_rst_n=0 and drive writes plus reads of r5 and r31 -> o_rdata1, o_rdata2, o_hi and o_lo are all 0; after release, reading r5 -> 0.

REQ-018 Write then read: write r7=0xDEADBEEF in cycle N; in cycle N+1 with i_re1=1, i_raddr1=7 -> o_rdata1=0xDEADBEEF; with i_re1=0 -> 0.

REQ-019 Zero register: write r0=0x12345678, then read port 2 at address 0 -> o_rdata2=0x00000000.

REQ-020 Bypass: in the same cycle, write r9=0xA5A5A5A5 and read r9 on both ports, with r9 previously 0x1 -> with REGFILE_BYPASS_EN both ports read 0xA5A5A5A5; without it both read 0x00000001, then 0xA5A5A5A5 in the next cycle.

REQ-021 HI/LO: i_wb_hilo_wen=1, hi=0x11112222, lo=0x33334444 for one cycle -> next cycle o_hi=0x11112222 and o_lo=0x33334444; a GPR write of r3 in the same cycle also lands.

REQ-022 Reset mid-operation: assert i_rst_n=0 between edges while i_wb_wen=1 to r4=0xFF -> r4 reads 0 after reset, and previously written r7 also reads 0.
